// File: rtl/ts_pkg.sv
// rtl/ts_pkg.sv - shared TS constants, AFC encodings and PID-table entry type
package ts_pkg;

  localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;
  localparam int          TS_PKT_LEN   = 188;
  localparam logic [12:0] TS_NULL_PID  = 13'h1FFF;

  typedef enum logic [1:0] {
    AFC_RSVD    = 2'b00,
    AFC_PAYLOAD = 2'b01,
    AFC_ADAPT   = 2'b10,
    AFC_BOTH    = 2'b11
  } afc_t;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'b00,
    ST_VERIFY = 2'b01,
    ST_LOCKED = 2'b10
  } sync_state_t;

  typedef struct packed {
    logic        valid;
    logic [12:0] pid;
    logic [3:0]  last_cc;
    logic        dup;
  } pid_entry_t;

  function automatic logic afc_has_payload(input logic [1:0] afc);
    return (afc_t'(afc) == AFC_PAYLOAD) || (afc_t'(afc) == AFC_BOTH);
  endfunction

endpackage

// File: rtl/ts_sync_fsm.sv
// rtl/ts_sync_fsm.sv - 188-byte packet alignment: HUNT/VERIFY/LOCKED with flywheel
module ts_sync_fsm
  import ts_pkg::*;
#(
  parameter int PKT_LEN    = TS_PKT_LEN,
  parameter int LOCK_CNT   = 3,
  parameter int UNLOCK_CNT = 3,
  parameter int IDX_W      = $clog2(PKT_LEN)
) (
  input  logic             rclk,
  input  logic             reset_n,
  input  logic [7:0]       din,
  input  logic             din_valid,
  output logic             locked,
  output logic [IDX_W-1:0] idx,
  output logic             fwd,
  output logic             sop,
  output logic             lock_lost
);

  localparam int CNT_W = 4;

  sync_state_t      state;
  logic [CNT_W-1:0] hits;
  logic [CNT_W-1:0] misses;
  logic             is_sync;
  logic             at_sop;
  logic             lock_now;
  logic             drop_now;
  logic [IDX_W-1:0] idx_inc;

  always_comb begin
    is_sync  = (din == TS_SYNC_BYTE);
    at_sop   = din_valid && (idx == '0);
    idx_inc  = (idx == IDX_W'(PKT_LEN - 1)) ? '0 : idx + 1'b1;
    lock_now = (state == ST_VERIFY) && at_sop && is_sync && (hits == CNT_W'(LOCK_CNT - 1));
    drop_now = (state == ST_LOCKED) && at_sop && !is_sync && (misses == CNT_W'(UNLOCK_CNT - 1));
    // The byte that completes lock is forwarded; the byte that drops lock is not.
    fwd       = din_valid && ((locked && !drop_now) || lock_now);
    sop       = fwd && (idx == '0);
    lock_lost = drop_now;
  end

  always_ff @(posedge rclk) begin
    if (!reset_n) begin
      state  <= ST_HUNT;
      idx    <= '0;
      hits   <= '0;
      misses <= '0;
      locked <= 1'b0;
    end else if (din_valid) begin
      case (state)
        ST_HUNT: begin
          if (is_sync) begin
            state <= ST_VERIFY;
            idx   <= IDX_W'(1);
            hits  <= CNT_W'(1);
          end
        end
        ST_VERIFY: begin
          idx <= idx_inc;
          if (idx == '0) begin
            if (!is_sync) begin
              state <= ST_HUNT;
              idx   <= '0;
              hits  <= '0;
            end else if (lock_now) begin
              state  <= ST_LOCKED;
              locked <= 1'b1;
              misses <= '0;
            end else begin
              hits <= hits + 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          idx <= idx_inc;
          if (idx == '0) begin
            if (is_sync) begin
              misses <= '0;
            end else if (drop_now) begin
              state  <= ST_HUNT;
              locked <= 1'b0;
              idx    <= '0;
              misses <= '0;
              hits   <= '0;
            end else begin
              misses <= misses + 1'b1;
            end
          end
        end
        default: begin
          state  <= ST_HUNT;
          locked <= 1'b0;
          idx    <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ts_cc_monitor.sv
// rtl/ts_cc_monitor.sv - per-channel TS sync lock, aligned forwarding and per-PID CC monitor
module ts_cc_monitor
  import ts_pkg::*;
#(
  parameter int PKT_LEN    = TS_PKT_LEN,
  parameter int LOCK_CNT   = 3,
  parameter int UNLOCK_CNT = 3,
  parameter int NUM_PIDS   = 8
) (
  input  logic        rclk,
  input  logic        reset_n,
  input  logic [7:0]  din,
  input  logic        din_valid,
  input  logic        clr_stats,
  output logic [7:0]  dout,
  output logic        dout_valid,
  output logic        dout_sop,
  output logic        sync_locked,
  output logic        cc_err,
  output logic [12:0] cc_err_pid,
  output logic [15:0] lost_pkts,
  output logic [31:0] pkt_cnt,
  output logic [7:0]  sync_loss_cnt,
  output logic        table_full
);

  localparam int IDX_W = $clog2(PKT_LEN);
  localparam int TBL_W = (NUM_PIDS > 1) ? $clog2(NUM_PIDS) : 1;

  logic             locked;
  logic [IDX_W-1:0] idx;
  logic             fwd;
  logic             sop;
  logic             lock_lost;

  ts_sync_fsm #(
    .PKT_LEN    (PKT_LEN),
    .LOCK_CNT   (LOCK_CNT),
    .UNLOCK_CNT (UNLOCK_CNT),
    .IDX_W      (IDX_W)
  ) u_sync (
    .rclk      (rclk),
    .reset_n   (reset_n),
    .din       (din),
    .din_valid (din_valid),
    .locked    (locked),
    .idx       (idx),
    .fwd       (fwd),
    .sop       (sop),
    .lock_lost (lock_lost)
  );

  pid_entry_t       tbl [NUM_PIDS];
  logic             hdr_tei;
  logic [12:0]      hdr_pid;

  logic             hdr_byte;
  logic             chk;
  logic [3:0]       cc_in;
  logic [1:0]       afc_in;
  logic             hit;
  logic [TBL_W-1:0] hit_idx;
  logic             free;
  logic [TBL_W-1:0] free_idx;
  logic [3:0]       hit_cc;
  logic             hit_dup;
  logic             err;
  logic             add_lost;
  logic             new_dup;
  logic [3:0]       gap;
  logic [16:0]      lost_sum;
  logic [15:0]      lost_sat;

  always_comb begin
    hdr_byte = locked && din_valid;
    cc_in    = din[3:0];
    afc_in   = din[5:4];
    chk      = hdr_byte && (idx == IDX_W'(3)) && !hdr_tei && (hdr_pid != TS_NULL_PID);

    // Descending scan so the lowest matching/free slot wins.
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int i = NUM_PIDS - 1; i >= 0; i--) begin
      if (tbl[i].valid && (tbl[i].pid == hdr_pid)) begin
        hit     = 1'b1;
        hit_idx = TBL_W'(i);
      end
      if (!tbl[i].valid) begin
        free     = 1'b1;
        free_idx = TBL_W'(i);
      end
    end

    hit_cc   = tbl[hit_idx].last_cc;
    hit_dup  = tbl[hit_idx].dup;
    gap      = cc_in - hit_cc - 4'd1;
    err      = 1'b0;
    add_lost = 1'b0;
    new_dup  = hit_dup;
    if (!afc_has_payload(afc_in)) begin
      err = (cc_in != hit_cc);
    end else if (cc_in == hit_cc + 4'd1) begin
      new_dup = 1'b0;
    end else if (cc_in == hit_cc) begin
      if (!hit_dup) new_dup = 1'b1;
      else          err     = 1'b1;
    end else begin
      err      = 1'b1;
      add_lost = 1'b1;
    end

    lost_sum = {1'b0, lost_pkts} + {13'd0, gap};
    lost_sat = lost_sum[16] ? 16'hFFFF : lost_sum[15:0];
  end

  always_ff @(posedge rclk) begin
    if (!reset_n) begin
      dout          <= '0;
      dout_valid    <= 1'b0;
      dout_sop      <= 1'b0;
      cc_err        <= 1'b0;
      cc_err_pid    <= '0;
      lost_pkts     <= '0;
      pkt_cnt       <= '0;
      sync_loss_cnt <= '0;
      table_full    <= 1'b0;
      hdr_tei       <= 1'b0;
      hdr_pid       <= '0;
      for (int i = 0; i < NUM_PIDS; i++) tbl[i] <= '0;
    end else begin
      dout_valid <= fwd;
      dout_sop   <= sop;
      if (fwd) dout <= din;

      cc_err <= chk && hit && err;
      if (chk && hit && err) cc_err_pid <= hdr_pid;

      if (hdr_byte && (idx == IDX_W'(1))) begin
        hdr_tei       <= din[7];
        hdr_pid[12:8] <= din[4:0];
      end
      if (hdr_byte && (idx == IDX_W'(2))) hdr_pid[7:0] <= din;

      if (clr_stats) begin
        lost_pkts     <= '0;
        pkt_cnt       <= '0;
        sync_loss_cnt <= '0;
        table_full    <= 1'b0;
        for (int i = 0; i < NUM_PIDS; i++) tbl[i] <= '0;
      end else begin
        if (sop) pkt_cnt <= pkt_cnt + 32'd1;
        if (lock_lost) begin
          if (sync_loss_cnt != 8'hFF) sync_loss_cnt <= sync_loss_cnt + 8'd1;
          for (int i = 0; i < NUM_PIDS; i++) tbl[i] <= '0;
        end
        if (chk && hit) begin
          tbl[hit_idx].last_cc <= cc_in;
          tbl[hit_idx].dup     <= new_dup;
          if (add_lost) lost_pkts <= lost_sat;
        end else if (chk && free) begin
          tbl[free_idx] <= '{valid: 1'b1, pid: hdr_pid, last_cc: cc_in, dup: 1'b0};
        end else if (chk) begin
          table_full <= 1'b1;
        end
      end
    end
  end

  assign sync_locked = locked;

endmodule

// File: tb/tb_ts_cc_monitor.sv
// tb/tb_ts_cc_monitor.sv - directed self-checking bench for ts_cc_monitor
module tb_ts_cc_monitor;
  import ts_pkg::*;

  logic        rclk = 1'b0;
  logic        reset_n;
  logic [7:0]  din;
  logic        din_valid;
  logic        clr_stats;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_sop;
  logic        sync_locked;
  logic        cc_err;
  logic [12:0] cc_err_pid;
  logic [15:0] lost_pkts;
  logic [31:0] pkt_cnt;
  logic [7:0]  sync_loss_cnt;
  logic        table_full;

  ts_cc_monitor dut (
    .rclk          (rclk),
    .reset_n       (reset_n),
    .din           (din),
    .din_valid     (din_valid),
    .clr_stats     (clr_stats),
    .dout          (dout),
    .dout_valid    (dout_valid),
    .dout_sop      (dout_sop),
    .sync_locked   (sync_locked),
    .cc_err        (cc_err),
    .cc_err_pid    (cc_err_pid),
    .lost_pkts     (lost_pkts),
    .pkt_cnt       (pkt_cnt),
    .sync_loss_cnt (sync_loss_cnt),
    .table_full    (table_full)
  );

  always #5 rclk = ~rclk;

  int         checks = 0;
  int         errors = 0;
  int         err_pulses = 0;
  int         sop_seen = 0;
  bit         gap_en = 1'b0;
  logic       s0_locked, s0_sop, s3_err, s3_full;
  logic [7:0] s0_dout;
  logic [3:0] rc [16];

  always @(negedge rclk) begin
    if (reset_n === 1'b1) begin
      if (cc_err === 1'b1)   err_pulses++;
      if (dout_sop === 1'b1) sop_seen++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    if (gap_en && ($urandom_range(0, 1) == 1)) begin
      @(negedge rclk);
      din       = 8'h47;
      din_valid = 1'b0;
    end
    @(negedge rclk);
    din       = b;
    din_valid = 1'b1;
    @(posedge rclk);
    #1;
  endtask

  task automatic idle();
    @(negedge rclk);
    din_valid = 1'b0;
    @(posedge rclk);
    #1;
  endtask

  task automatic send_pkt(input logic [12:0] pid, input logic [3:0] cc, input logic [1:0] afc,
                          input logic tei, input logic good_sync, input int len);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      case (i)
        0:       b = good_sync ? 8'h47 : 8'h00;
        1:       b = {tei, 2'b00, pid[12:8]};
        2:       b = pid[7:0];
        3:       b = {2'b00, afc, cc};
        default: b = 8'hFF;
      endcase
      send_byte(b);
      if (i == 0) begin
        s0_locked = sync_locked;
        s0_sop    = dout_sop;
        s0_dout   = dout;
      end
      if (i == 3) begin
        s3_err  = cc_err;
        s3_full = table_full;
      end
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    din       = 8'h00;
    din_valid = 1'b0;
    clr_stats = 1'b0;
    repeat (3) @(posedge rclk);
    #1;
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_dout_sop", dout_sop, 0);
    chk("rst_locked", sync_locked, 0);
    chk("rst_cc_err", cc_err, 0);
    chk("rst_stats", {lost_pkts, sync_loss_cnt, 7'd0, table_full}, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    @(negedge rclk);
    reset_n = 1'b1;

    // Lock on a clean stream
    for (int c = 0; c < 5; c++) begin
      send_pkt(13'h100, 4'(c), 2'b01, 1'b0, 1'b1, 188);
      if (c == 1) chk("lock_not_yet", s0_locked, 0);
      if (c == 2) begin
        chk("lock_rise", s0_locked, 1);
        chk("lock_first_sop", s0_sop, 1);
        chk("lock_first_dout", s0_dout, 8'h47);
        chk("lock_first_alloc_err", s3_err, 0);
      end
    end
    chk("lock_pkt_cnt", pkt_cnt, 3);
    chk("lock_err_pulses", err_pulses, 0);
    chk("lock_lost", lost_pkts, 0);
    chk("lock_sop_seen", sop_seen, 3);

    // Two lost packets
    send_pkt(13'h100, 4'd5, 2'b01, 1'b0, 1'b1, 188);
    send_pkt(13'h100, 4'd6, 2'b01, 1'b0, 1'b1, 188);
    send_pkt(13'h100, 4'd9, 2'b01, 1'b0, 1'b1, 188);
    chk("loss_err_pulse", s3_err, 1);
    chk("loss_err_cleared", cc_err, 0);
    chk("loss_lost", lost_pkts, 2);
    chk("loss_pid", cc_err_pid, 13'h100);
    chk("loss_err_pulses", err_pulses, 1);

    // Duplicate handling and no-payload AFC
    send_pkt(13'h100, 4'd10, 2'b01, 1'b0, 1'b1, 188);
    chk("dup_next_ok", s3_err, 0);
    send_pkt(13'h100, 4'd10, 2'b01, 1'b0, 1'b1, 188);
    chk("dup_first_ok", s3_err, 0);
    send_pkt(13'h100, 4'd10, 2'b01, 1'b0, 1'b1, 188);
    chk("dup_second_err", s3_err, 1);
    send_pkt(13'h100, 4'd10, 2'b10, 1'b0, 1'b1, 188);
    chk("afc10_same_ok", s3_err, 0);
    chk("dup_lost", lost_pkts, 2);
    chk("dup_err_pulses", err_pulses, 2);
    chk("dup_pkt_cnt", pkt_cnt, 10);

    // Three bad syncs drop lock; flywheel packets still processed
    send_pkt(13'h100, 4'd11, 2'b01, 1'b0, 1'b0, 188);
    chk("fly1_locked", s0_locked, 1);
    chk("fly1_sop", s0_sop, 1);
    send_pkt(13'h100, 4'd12, 2'b01, 1'b0, 1'b0, 188);
    chk("fly2_locked", s0_locked, 1);
    send_pkt(13'h100, 4'd13, 2'b01, 1'b0, 1'b0, 188);
    chk("unlock_fall", s0_locked, 0);
    chk("unlock_loss_cnt", sync_loss_cnt, 1);
    chk("unlock_pkt_cnt", pkt_cnt, 12);
    for (int c = 0; c < 4; c++) begin
      send_pkt(13'h100, 4'(c), 2'b01, 1'b0, 1'b1, 188);
      if (c == 1) chk("relock_not_yet", s0_locked, 0);
      if (c == 2) begin
        chk("relock_rise", s0_locked, 1);
        chk("relock_realloc_no_err", s3_err, 0);
      end
    end
    chk("relock_err_pulses", err_pulses, 2);
    chk("relock_pkt_cnt", pkt_cnt, 14);

    // Fill the table, overflow, null PID, TEI
    for (int p = 1; p <= 8; p++) begin
      rc[p] = 4'($urandom_range(0, 15));
      send_pkt(13'h100 + 13'(p), rc[p], 2'b01, 1'b0, 1'b1, 188);
      if (p == 7) chk("tbl_not_full", s3_full, 0);
      if (p == 8) begin
        chk("tbl_full_set", s3_full, 1);
        chk("tbl_full_no_err", s3_err, 0);
      end
    end
    send_pkt(13'h108, rc[8] + 4'd5, 2'b01, 1'b0, 1'b1, 188);
    chk("tbl_full_again_no_err", s3_err, 0);
    send_pkt(TS_NULL_PID, 4'd3, 2'b01, 1'b0, 1'b1, 188);
    send_pkt(TS_NULL_PID, 4'd9, 2'b01, 1'b0, 1'b1, 188);
    chk("null_no_err", s3_err, 0);
    send_pkt(13'h101, rc[1] + 4'd5, 2'b01, 1'b1, 1'b1, 188);
    chk("tei_no_err", s3_err, 0);
    send_pkt(13'h105, rc[5] + 4'd3, 2'b01, 1'b0, 1'b1, 188);
    chk("tbl_hit5_err", s3_err, 1);
    chk("tbl_hit5_pid", cc_err_pid, 13'h105);
    chk("tbl_lost", lost_pkts, 4);
    chk("tbl_table_full", table_full, 1);
    chk("tbl_pkt_cnt", pkt_cnt, 27);

    // Random din_valid gaps
    gap_en = 1'b1;
    send_pkt(13'h100, 4'd4, 2'b01, 1'b0, 1'b1, 188);
    chk("gap_ok", s3_err, 0);
    send_pkt(13'h100, 4'd5, 2'b01, 1'b0, 1'b1, 188);
    send_pkt(13'h100, 4'd8, 2'b01, 1'b0, 1'b1, 188);
    chk("gap_err", s3_err, 1);
    gap_en = 1'b0;
    idle();
    chk("gap_idle_valid", dout_valid, 0);
    chk("gap_idle_locked", sync_locked, 1);
    chk("gap_lost", lost_pkts, 6);
    chk("gap_err_pulses", err_pulses, 4);
    chk("gap_pkt_cnt", pkt_cnt, 30);
    chk("gap_sop_seen", sop_seen, 30);

    // Statistics clear keeps sync
    @(negedge rclk);
    clr_stats = 1'b1;
    @(posedge rclk);
    #1;
    chk("clr_lost", lost_pkts, 0);
    chk("clr_pkt_cnt", pkt_cnt, 0);
    chk("clr_loss_full", {sync_loss_cnt, table_full}, 0);
    chk("clr_locked", sync_locked, 1);
    @(negedge rclk);
    clr_stats = 1'b0;
    send_pkt(13'h100, 4'd0, 2'b01, 1'b0, 1'b1, 188);
    chk("clr_realloc_no_err", s3_err, 0);
    chk("clr_pkt_cnt_after", pkt_cnt, 1);

    // Reset mid-packet requires full re-lock
    send_pkt(13'h100, 4'd1, 2'b01, 1'b0, 1'b1, 50);
    @(negedge rclk);
    reset_n   = 1'b0;
    din_valid = 1'b0;
    @(posedge rclk);
    #1;
    chk("mid_rst_locked", sync_locked, 0);
    chk("mid_rst_pkt_cnt", pkt_cnt, 0);
    chk("mid_rst_err_pid", cc_err_pid, 0);
    @(negedge rclk);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      send_pkt(13'h100, 4'(c), 2'b01, 1'b0, 1'b1, 188);
      if (c == 1) chk("rst_relock_not_yet", s0_locked, 0);
    end
    chk("rst_relock_rise", s0_locked, 1);
    chk("rst_relock_sop", s0_sop, 1);
    chk("rst_relock_pkt_cnt", pkt_cnt, 1);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
